// File: rtl/jk_seq_pkg.sv
// rtl/jk_seq_pkg.sv - shared op encodings, FSM state type and JK next-state function
package jk_seq_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic q_n;
        case ({j, k})
            2'b00:   q_n = q;
            2'b01:   q_n = 1'b0;
            2'b10:   q_n = 1'b1;
            default: q_n = ~q;
        endcase
        return q_n;
    endfunction

endpackage

// File: rtl/jk_shadow_model.sv
// rtl/jk_shadow_model.sv - behavioural copy of the downstream JK flops with sticky Q mismatch flag
module jk_shadow_model
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             mismatch
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_nxt;

    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < WIDTH; i++) begin
            shadow_nxt[i] = jk_next(shadow[i], j[i], k[i]);
        end
    end

    // Shadow and the real flops see the same registered j/k at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow   <= '0;
            mismatch <= 1'b0;
        end else begin
            shadow   <= shadow_nxt;
            mismatch <= clr ? 1'b0 : (mismatch | (q_fb != shadow));
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// rtl/jk_cmd_sequencer.sv - command sequencer driving J/K vectors; optional shadow check via JK_SEQ_SHADOW_CHECK_EN
module jk_cmd_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             abort,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done
`ifdef JK_SEQ_SHADOW_CHECK_EN
    ,
    input  logic [WIDTH-1:0] q_fb,
    output logic             mismatch
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       GAP_ONE  = 8'd1;
    localparam logic [7:0]       GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_cnt_nxt;
    logic [7:0]       gap_cnt;
    logic [7:0]       gap_cnt_nxt;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;
    logic             done_nxt;
    logic             hs;

    assign cmd_ready = rst_n && (state == IDLE) && !abort;
    assign hs        = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters hold "remaining cycles minus one" so the exit test is a compare with zero.
    always_comb begin
        state_nxt   = state;
        run_cnt_nxt = run_cnt;
        gap_cnt_nxt = gap_cnt;
        j_nxt       = '0;
        k_nxt       = '0;
        done_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (hs) begin
                    state_nxt   = RUN;
                    run_cnt_nxt = (cmd_len == '0) ? '0 : (cmd_len - CNT_ONE);
                    j_nxt       = cmd_mask & {WIDTH{cmd_op[1]}};
                    k_nxt       = cmd_mask & {WIDTH{cmd_op[0]}};
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    run_cnt_nxt = '0;
                end else if (run_cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = GAP_LOAD;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    run_cnt_nxt = run_cnt - CNT_ONE;
                    j_nxt       = j;
                    k_nxt       = k;
                end
            end
            GAP: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    gap_cnt_nxt = '0;
                end else if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt - GAP_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            gap_cnt <= '0;
            j       <= '0;
            k       <= '0;
            done    <= 1'b0;
        end else begin
            run_cnt <= run_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            j       <= j_nxt;
            k       <= k_nxt;
            done    <= done_nxt;
        end
    end

`ifdef JK_SEQ_SHADOW_CHECK_EN
    jk_shadow_model #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort),
        .j        (j),
        .k        (k),
        .q_fb     (q_fb),
        .mismatch (mismatch)
    );
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb/tb_jk_cmd_sequencer.sv - two sequencer instances (gap 1 and gap 0) checked against a timeline model
module tb_jk_cmd_sequencer;
    import jk_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_mask = 4'b0000;
    logic [7:0] cmd_len = 8'd0;

    logic [3:0] dj [2];
    logic [3:0] dk [2];
    logic       drdy [2];
    logic       dbusy [2];
    logic       ddone [2];

    always #5 clk = ~clk;

`ifdef JK_SEQ_SHADOW_CHECK_EN
    logic [3:0] ext_q;
    logic [3:0] flip = 4'b0000;
    logic [3:0] q_fb;
    logic       mm;
    logic       mm0;
    assign q_fb = ext_q ^ flip;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ext_q <= 4'b0000;
        else for (int i = 0; i < 4; i++) ext_q[i] <= jk_next(ext_q[i], dj[0][i], dk[0][i]);
    end
`endif

    jk_cmd_sequencer #(.WIDTH(4), .CNT_W(8), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(drdy[0]),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len), .abort(abort),
        .j(dj[0]), .k(dk[0]), .busy(dbusy[0]), .done(ddone[0])
`ifdef JK_SEQ_SHADOW_CHECK_EN
        , .q_fb(q_fb), .mismatch(mm)
`endif
    );

    jk_cmd_sequencer #(.WIDTH(4), .CNT_W(8), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(drdy[1]),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len), .abort(abort),
        .j(dj[1]), .k(dk[1]), .busy(dbusy[1]), .done(ddone[1])
`ifdef JK_SEQ_SHADOW_CHECK_EN
        , .q_fb(4'b0000), .mismatch(mm0)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: each accepted command owns fixed cycle windows.
    int         gapc [2] = '{1, 0};
    bit         act_m [2] = '{0, 0};
    int         rs [2] = '{0, 0};
    int         re [2] = '{0, 0};
    int         ia [2] = '{0, 0};
    int         done_at [2] = '{-1, -1};
    logic [3:0] mj [2];
    logic [3:0] mk [2];
    int         cyc = 0;
    int         hs_cnt [2] = '{0, 0};
    int         hs_q1 [$];

    function automatic bit busy_m(input int i, input int c);
        return act_m[i] && (c >= rs[i]) && (c < ia[i]);
    endfunction

    always @(negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            act_m[i]   = 1'b0;
            done_at[i] = -1;
        end
    end

    initial begin
        int len_m;
        bit in_run;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst_n) begin
                    if (busy_m(i, cyc) && abort) begin
                        act_m[i]   = 1'b0;
                        done_at[i] = -1;
                    end else if (!busy_m(i, cyc) && cmd_valid && !abort) begin
                        len_m      = (cmd_len == 8'd0) ? 1 : int'(cmd_len);
                        rs[i]      = cyc + 1;
                        re[i]      = cyc + len_m;
                        ia[i]      = cyc + len_m + gapc[i] + 1;
                        done_at[i] = ia[i];
                        act_m[i]   = 1'b1;
                        mj[i]      = cmd_mask & {4{cmd_op[1]}};
                        mk[i]      = cmd_mask & {4{cmd_op[0]}};
                        hs_cnt[i]++;
                        if (i == 1) hs_q1.push_back(cyc);
                    end
                end
            end
            cyc++;
            #1;
            for (int i = 0; i < 2; i++) begin
                in_run = act_m[i] && (cyc >= rs[i]) && (cyc <= re[i]);
                chk($sformatf("model_j%0d", i), dj[i], in_run ? mj[i] : 4'b0000);
                chk($sformatf("model_k%0d", i), dk[i], in_run ? mk[i] : 4'b0000);
                chk($sformatf("model_busy%0d", i), dbusy[i], busy_m(i, cyc));
                chk($sformatf("model_done%0d", i), ddone[i], done_at[i] == cyc);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_ready%0d", i), drdy[i], rst_n && !busy_m(i, cyc) && !abort);
            end
        end
    end

    task automatic settle(input int n);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_set();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_mask = 4'b0101; cmd_len = 8'd3;
        #1 chk("set_ready", drdy[0], 1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = OP_TGL; cmd_mask = 4'b1111; cmd_len = 8'd9;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            chk("set_j", dj[0], 4'b0101);
            chk("set_k", dk[0], 4'b0000);
        end
        @(negedge clk); #1;
        chk("set_gap_j", dj[0], 0);
        chk("set_gap_busy", dbusy[0], 1);
        chk("set_gap_done", ddone[0], 0);
        @(negedge clk); #1;
        chk("set_done", ddone[0], 1);
        chk("set_ready_after", drdy[0], 1);
        chk("set_busy_after", dbusy[0], 0);
    endtask

    task automatic test_tgl1();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_TGL; cmd_mask = 4'b1111; cmd_len = 8'd0;
        @(negedge clk); cmd_valid = 1'b0; #1;
        chk("tgl_j", dj[0], 4'b1111);
        chk("tgl_k", dk[0], 4'b1111);
        @(negedge clk); #1;
        chk("tgl_gap_j", dj[0], 0);
        chk("tgl_gap_done", ddone[0], 0);
        @(negedge clk); #1;
        chk("tgl_done", ddone[0], 1);
    endtask

    task automatic test_abort();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_TGL; cmd_mask = 4'b1010; cmd_len = 8'd200;
        @(negedge clk); cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        #1 chk("abort_run_j", dj[0], 4'b1010);
        @(negedge clk); abort = 1'b0; #1;
        chk("abort_j", dj[0], 0);
        chk("abort_k", dk[0], 0);
        chk("abort_busy", dbusy[0], 0);
        chk("abort_done", ddone[0], 0);
        chk("abort_ready", drdy[0], 1);
    endtask

    task automatic test_idle_abort();
        @(negedge clk);
        cmd_valid = 1'b1; abort = 1'b1; cmd_op = OP_SET; cmd_mask = 4'b1111; cmd_len = 8'd2;
        #1 chk("idle_abort_ready", drdy[0], 0);
        @(negedge clk); cmd_valid = 1'b0; abort = 1'b0; #1;
        chk("idle_abort_busy0", dbusy[0], 0);
        chk("idle_abort_busy1", dbusy[1], 0);
    endtask

    task automatic test_queue();
        int lens [4] = '{2, 1, 4, 1};
        int start;
        int b;
        hs_q1.delete();
        start = hs_cnt[1];
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_mask = 4'b0011; cmd_len = 8'(lens[0]);
        for (int n = 1; n <= 4; n++) begin
            b = 0;
            while (hs_cnt[1] < start + n && b < 20) begin
                @(negedge clk);
                b++;
            end
            if (b >= 20) chk("queue_timeout", hs_cnt[1] - start, n);
            if (n < 4) begin
                cmd_len  = 8'(lens[n]);
                cmd_op   = (n % 2 == 1) ? OP_CLR : OP_TGL;
                cmd_mask = 4'(n + 5);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        chk("queue_count", hs_q1.size(), 4);
        if (hs_q1.size() == 4) begin
            chk("queue_space0", hs_q1[1] - hs_q1[0], 3);
            chk("queue_space1", hs_q1[2] - hs_q1[1], 2);
            chk("queue_space2", hs_q1[3] - hs_q1[2], 5);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_HOLD; cmd_mask = 4'b1111; cmd_len = 8'd2;
        @(negedge clk); cmd_valid = 1'b0; #1;
        chk("hold_j", dj[0], 0);
        chk("hold_busy", dbusy[0], 1);
        repeat (3) @(negedge clk);
        #1 chk("hold_done", ddone[0], 1);
    endtask

    task automatic test_reset();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_mask = 4'b1111; cmd_len = 8'd10;
        @(negedge clk); cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_j", dj[i], 0);
            chk("rst_k", dk[i], 0);
            chk("rst_busy", dbusy[i], 0);
            chk("rst_ready", drdy[i], 0);
        end
        @(negedge clk); rst_n = 1'b1;
        settle(2);
        test_set();
    endtask

    task automatic test_long();
        int cnt = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_SET; cmd_mask = 4'b1000; cmd_len = 8'd255;
        for (int b = 0; b < 300; b++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (dbusy[1]) cnt++;
            else if (cnt > 0) break;
        end
        chk("long_run_cycles", cnt, 255);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_j", dj[0], 0);
        chk("reset_busy", dbusy[0], 0);
        chk("reset_done", ddone[0], 0);
        chk("reset_ready", drdy[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        settle(2);
        test_set();        settle(3);
        test_tgl1();       settle(3);
        test_abort();      settle(3);
        test_idle_abort(); settle(2);
        test_queue();      settle(10);
        test_hold();       settle(3);
        test_reset();      settle(3);
        test_long();       settle(4);
`ifdef JK_SEQ_SHADOW_CHECK_EN
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_mask  = 4'($urandom_range(0, 15));
            cmd_len   = 8'($urandom_range(0, 3));
            @(negedge clk); cmd_valid = 1'b0;
            for (int b = 0; b < 10 && dbusy[0]; b++) @(negedge clk);
        end
        #1 chk("shadow_clean", mm, 0);
        @(negedge clk); flip = 4'b0100;
        @(negedge clk); flip = 4'b0000; #1;
        chk("shadow_set", mm, 1);
        @(negedge clk); #1 chk("shadow_sticky", mm, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0; #1;
        chk("shadow_cleared", mm, 0);
        settle(3);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
